// File: rtl/hazard_pkg.sv
// Shared types for the in-order hazard controller: tracker entry layout and FSM encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

    // Register addresses are stored zero-extended to this width inside the tracker.
    localparam int AW_MAX = 8;

    // Select value meaning "read the register file, no forwarding".
    localparam int SEL_RF = 0;

    // One in-flight destination tracked per downstream stage.
    typedef struct packed {
        logic              vld;
        logic [AW_MAX-1:0] dst;
        logic              ld;
    } trk_entry_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    typedef enum logic {
        FL_IDLE   = 1'b0,
        FL_JFLUSH = 1'b1
    } fl_state_t;

endpackage

// File: rtl/hazard_unit_p_fwd_match.sv
// Priority match of one decode source against the tracked downstream destinations.
// Latency: purely combinational.
// Backpressure: none; ld_hit tells the caller that the youngest match is a load still in flight.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int FWD_DEPTH = 2,
    parameter int LD_LAT    = 1,
    parameter int SW        = $clog2(FWD_DEPTH + 1)
) (
    input  trk_entry_t [FWD_DEPTH-1:0] ent,
    input  logic                       src_en,
    input  logic [AW_MAX-1:0]          src,
    output logic [SW-1:0]              sel,
    output logic                       ld_hit
);

    // Scan oldest to youngest so the youngest matching stage overwrites older ones.
    always_comb begin
        sel    = SW'(SEL_RF);
        ld_hit = 1'b0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (src_en && (src != '0) && ent[k-1].vld && (ent[k-1].dst == src)) begin
                sel    = SW'(k);
                ld_hit = ent[k-1].ld && (k <= LD_LAT);
            end
        end
    end

endmodule

// File: rtl/hazard_unit_p.sv
// Decode-side hazard controller: forwarding selects, load-use/cache-miss/mul-div stalls, jump/mispredict flushes.
// Latency: selects, stalls and flush are combinational from decode inputs and one cycle of tracked state.
// Backpressure: fd_st/de_st/em_st hold IF/ID, ID/EX, EX/MEM; a D-miss freezes the whole tracker.
module hazard_unit_p
    import hazard_pkg::*;
#(
    parameter int AW        = 5,
    parameter int FWD_DEPTH = 2,
    parameter int LD_LAT    = 1,
    parameter int SW        = $clog2(FWD_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic          id_dst_en,
    input  logic [AW-1:0] id_dst,
    input  logic          id_src1_en,
    input  logic          id_src2_en,
    input  logic [AW-1:0] id_src1,
    input  logic [AW-1:0] id_src2,
    input  logic          id_is_load,
    input  logic          id_is_j,
    input  logic          id_is_b,
    input  logic          id_is_md,
    input  logic          id_pre_taken,
    input  logic          ex_real_taken,
    input  logic          md_fin,
    input  logic          f_cmiss,
    input  logic          f_arrival,
    input  logic          m_cmiss,
    input  logic          m_arrival,
    output logic [SW-1:0] src1_sel,
    output logic [SW-1:0] src2_sel,
    output logic          fd_st,
    output logic          de_st,
    output logic          em_st,
    output logic          flush,
    output logic          mispred_nt,
    output logic          mispred_t,
    output logic          rs1_dep
);

    trk_entry_t [FWD_DEPTH-1:0] trk;
    trk_entry_t                 ins;
    md_state_t                  md_state;
    fl_state_t                  fl_state;

    logic ikeep, dkeep, imiss, dmiss;
    logic b_vld, b_pt;
    logic ld_hit1, ld_hit2, ldhaz;
    logic md_enter, mdst;
    logic flush_base, j_flush, fwd_any;

    fwd_match #(.FWD_DEPTH(FWD_DEPTH), .LD_LAT(LD_LAT), .SW(SW)) u_match1 (
        .ent    (trk),
        .src_en (id_src1_en),
        .src    (AW_MAX'(id_src1)),
        .sel    (src1_sel),
        .ld_hit (ld_hit1)
    );

    fwd_match #(.FWD_DEPTH(FWD_DEPTH), .LD_LAT(LD_LAT), .SW(SW)) u_match2 (
        .ent    (trk),
        .src_en (id_src2_en),
        .src    (AW_MAX'(id_src2)),
        .sel    (src2_sel),
        .ld_hit (ld_hit2)
    );

    // A refill arriving this cycle ends the miss immediately; a new miss counts from its first cycle.
    assign imiss = ~f_arrival & (f_cmiss | ikeep);
    assign dmiss = ~m_arrival & (m_cmiss | dkeep);

    assign mispred_nt = b_vld & b_pt & ~ex_real_taken;
    assign mispred_t  = b_vld & ~b_pt & ex_real_taken;

    // Flush sources that do not depend on this cycle's stalls; used to break the jump/stall loop.
    assign flush_base = (fl_state == FL_JFLUSH) | mispred_nt | mispred_t;

    // A flush squashes the dependent instruction, so a load-use hazard never stalls under it.
    assign ldhaz = (ld_hit1 | ld_hit2) & ~flush_base;

    // A jump can never be a mul/div, so excluding id_is_j here is equivalent to excluding the jump flush.
    assign md_enter = id_is_md & id_valid & ~flush_base & ~id_is_j & ~dmiss;
    assign mdst     = ((md_state == MD_IDLE) & md_enter & ~md_fin)
                    | ((md_state == MD_BUSY) & ~md_fin);

    assign fd_st = imiss | dmiss | ldhaz | mdst;
    assign de_st = ldhaz | dmiss;
    assign em_st = dmiss;

    assign j_flush = id_is_j & id_valid & ~flush_base & ~fd_st;
    assign flush   = flush_base | j_flush;

    assign fwd_any = (src1_sel != SW'(SEL_RF)) | (src2_sel != SW'(SEL_RF));
    assign rs1_dep = (src1_sel != SW'(SEL_RF));

    // Entry presented to stage 1; stalls and flushes turn it into a bubble, x0 is never tracked.
    always_comb begin
        ins     = '0;
        ins.vld = id_valid & id_dst_en & ~flush & ~de_st & (id_dst != '0);
        ins.dst = AW_MAX'(id_dst);
        ins.ld  = id_is_load;
    end

    // Shift the tracker one stage per cycle unless the back end is frozen by a D-miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            trk <= '0;
        end else if (!em_st) begin
            trk[0] <= ins;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                trk[k] <= trk[k-1];
            end
        end
    end

    // Miss-pending flags: a new miss wins over a simultaneous refill, reset drops any outstanding miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            ikeep <= 1'b0;
            dkeep <= 1'b0;
        end else begin
            if (f_cmiss)        ikeep <= 1'b1;
            else if (f_arrival) ikeep <= 1'b0;
            if (m_cmiss)        dkeep <= 1'b1;
            else if (m_arrival) dkeep <= 1'b0;
        end
    end

    // Branch slot of the ID/EX register; holds while EX/MEM is frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_vld <= 1'b0;
            b_pt  <= 1'b0;
        end else if (!em_st) begin
            b_vld <= id_is_b & id_valid & ~flush & ~de_st;
            b_pt  <= id_pre_taken;
        end
    end

    // Mul/div occupancy: busy from issue until md_fin, abandoned on flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_state <= MD_IDLE;
        end else if (md_state == MD_IDLE) begin
            if (md_enter && !md_fin) md_state <= MD_BUSY;
        end else begin
            if (md_fin || flush) md_state <= MD_IDLE;
        end
    end

    // A jump whose target operand is forwarded keeps flushing for one extra cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            fl_state <= FL_IDLE;
        end else if (fl_state == FL_IDLE) begin
            if (j_flush && fwd_any) fl_state <= FL_JFLUSH;
        end else begin
            fl_state <= FL_IDLE;
        end
    end

endmodule
